seg7_reader: RTL and testbench
==============================

# seg7_reader

Samples a multiplexed, active-low 7-segment display bus (segment lines plus per-digit enables) and recovers the decimal digit shown at each position. It is the inverse of the team's BCD-to-7-segment decoder. It is used to observe third-party display drivers and to self-check our own display path. A pattern must be stable for a programmable number of samples before it is accepted. Unknown patterns raise a sticky per-digit error.

## Interface
- `DIGITS`, default 4: number of digit positions, legal range 1..8.
- `STABLE`, default 4: consecutive identical samples required before capture, legal range 2..255.
- `clk`, input, 1: single clock; all registers on rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `seg_n`, input, 7: active-low segments. Bit 0 is the top segment, bits 1..5 proceed clockwise, bit 6 is the middle segment. Asynchronous to `clk`.
- `an_n`, input, DIGITS: active-low digit enables. Asynchronous to `clk`.
- `err_clr`, input, 1: synchronous pulse that clears all `err` bits.
- `bcd`, output, 4*DIGITS: captured digits; digit d occupies bits [4d+3:4d].
- `valid`, output, DIGITS: digit d holds a valid captured value.
- `err`, output, DIGITS: sticky; an illegal pattern was captured at digit d.
- `upd`, output, 1: one-cycle strobe on every capture.
- `upd_idx`, output, 3: digit index of the capture reported by `upd`.

## Operation
- **Input synchronisation.** `seg_n` and `an_n` pass through a 2-flop synchronizer. Synchronizer reset value is all ones, which represents an idle, blank display.
- **Sample qualification.** A sample is qualified when exactly one bit of the synchronized `an_n` is 0; that bit gives the digit index d. All-ones (blanking interval) and multiple-low samples are unqualified.
- **Run counter.** The block keeps `last_an`, `last_seg` and a run counter `run` (8 bits, saturating at STABLE).
  - Qualified sample equal to (`last_an`, `last_seg`): `run` increments.
  - Qualified sample that differs: `run` is set to 1 and `last_*` are loaded.
  - Unqualified sample: `run` is set to 0.
- **Capture.** Capture happens only on the edge where `run` goes from STABLE-1 to STABLE, i.e. exactly once per stable run. Holding the pattern longer does not re-capture. Capture decodes `last_seg` for digit d as follows (bit 6..0):
  - 0 = 1000000
  - 1 = 1111001
  - 2 = 0100100
  - 3 = 0110000
  - 4 = 0011001
  - 5 = 0010010
  - 6 = 0000010
  - 7 = 1111000 or 1011000 (both encodings accepted)
  - 8 = 0000000
  - 9 = 0010000
- **Capture result by pattern class.**
  - Legal digit: `bcd[d]` is written, `valid[d]`=1, `err[d]` is unchanged.
  - Blank (1111111): `valid[d]`=0, `bcd[d]` is unchanged, no error.
  - Any other pattern: `err[d]`=1, `valid[d]`=0, `bcd[d]` is unchanged.
  - Every capture pulses `upd`=1 for one cycle with `upd_idx`=d.
- **Error clearing.** `err_clr` clears all `err` bits. If `err_clr` coincides with an error capture on digit d, the set wins for d.
- **Reset.** At any time, including mid-run, `rst` forces:
  - `bcd`=0, `valid`=0, `err`=0, `upd`=0, `upd_idx`=0;
  - `run`=0, `last_an` and `last_seg` all ones, synchronizers all ones.

## Timing
- Inputs are applied before rising edge k and held. The synchronizer delivers them at edge k+2, giving `run`=1. Capture occurs at edge k+STABLE+1.
  - `bcd`, `valid`, `err`, `upd` and `upd_idx` are registered and change immediately after that edge.
  - `upd` falls after the following edge.
- Minimum digit dwell time that guarantees capture: STABLE cycles of `clk` per scan slot.
- A change of `an_n` or `seg_n` at any point before capture restarts the run. No partial pattern is ever captured.
- `err_clr` takes effect at the next edge with no latency beyond that edge.
- Asynchronous `rst` deassertion must meet recovery timing to `clk`; this is the integrator's responsibility.
- Throughput: one capture per scan slot. Back-to-back slots on different digits each produce their own `upd` pulse, at least STABLE cycles apart.

## Test plan
- **Reset.** Assert `rst` mid-run with `run`=3. All outputs are 0 asynchronously. After release, the next capture needs a full STABLE-sample run again.
- **Capture digit 2.** STABLE=4. Hold `an_n`=4'b1011, `seg_n`=7'b0110000 for 8 cycles from edge k.
  - After edge k+5: `bcd[11:8]`=3, `valid[2]`=1, `upd`=1 for exactly one cycle, `upd_idx`=2.
  - No further `upd` pulses.
- **Glitch rejection.** Hold `an_n`=4'b1110, `seg_n`=7'b1000000 for 3 cycles, then change to 7'b1111001. No `upd` pulse and `bcd[3:0]` is unchanged until the new pattern has been held for 4 cycles; then `bcd[3:0]`=1.
- **Illegal and blank patterns.**
  - Digit 0 stable at 7'b0001000: `err[0]`=1, `valid[0]`=0, `bcd[3:0]` is retained.
  - Then 7'b1111111 (blank): `valid[0]`=0 and `err[0]` stays 1.
  - `err_clr` pulse: `err`=0.
  - `err_clr` coincident with a new error capture on digit 0: `err[0]` stays 1.
- **Unqualified enables.** `an_n`=4'b1111 or 4'b0011, held for 10 cycles with a legal pattern on `seg_n`: no capture and `run` stays 0.
- **Full scan.** Round-robin across 4 digits with 6-cycle slots, showing digits 0..9 including both encodings of 7. Each slot yields one `upd` pulse with the correct `upd_idx` and `bcd` nibble, and `err` remains 0.

Source files
------------

// File: rtl/seg7_reader.sv
// Recovers decimal digits from a multiplexed active-low 7-segment bus.
// Capture is 2 sync cycles + STABLE samples after a pattern settles; no backpressure.
module seg7_reader #(
    parameter int DIGITS = 4,
    parameter int STABLE = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            seg_n,
    input  logic [DIGITS-1:0]     an_n,
    input  logic                  err_clr,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     valid,
    output logic [DIGITS-1:0]     err,
    output logic                  upd,
    output logic [2:0]            upd_idx
);

    logic [6:0]        seg_s1, seg_s2, last_seg;
    logic [DIGITS-1:0] an_s1, an_s2, last_an;
    logic [7:0]        run;

    logic [3:0]        nzero;
    logic [2:0]        idx;
    logic              qual, same, capture;
    logic [DIGITS-1:0] sel;
    logic [7:0]        run_nxt;

    logic [3:0]        dec_val;
    logic              dec_legal, dec_blank;

    // Synchronizers idle at all ones: a blank, unselected display.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_s1 <= '1;
            seg_s2 <= '1;
            an_s1  <= '1;
            an_s2  <= '1;
        end else begin
            seg_s1 <= seg_n;
            seg_s2 <= seg_s1;
            an_s1  <= an_n;
            an_s2  <= an_s1;
        end
    end

    always_comb begin
        nzero = '0;
        idx   = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!an_s2[i]) begin
                nzero = nzero + 4'd1;
                idx   = 3'(i);
            end
        end
    end

    assign sel     = ~an_s2;
    assign qual    = (nzero == 4'd1);
    assign same    = qual && (an_s2 == last_an) && (seg_s2 == last_seg);
    // Fires only on the STABLE-1 -> STABLE step, so a held pattern captures once.
    assign capture = same && (run == 8'(STABLE - 1));

    always_comb begin
        run_nxt = run;
        if (!qual)
            run_nxt = '0;
        else if (same)
            run_nxt = (run == 8'(STABLE)) ? run : run + 8'd1;
        else
            run_nxt = 8'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run      <= '0;
            last_an  <= '1;
            last_seg <= '1;
        end else begin
            run <= run_nxt;
            if (qual && !same) begin
                last_an  <= an_s2;
                last_seg <= seg_s2;
            end
        end
    end

    // Segment order is bit 6 (middle) down to bit 0 (top), active low.
    always_comb begin
        dec_val   = '0;
        dec_legal = 1'b1;
        dec_blank = 1'b0;
        case (last_seg)
            7'b1000000: dec_val = 4'd0;
            7'b1111001: dec_val = 4'd1;
            7'b0100100: dec_val = 4'd2;
            7'b0110000: dec_val = 4'd3;
            7'b0011001: dec_val = 4'd4;
            7'b0010010: dec_val = 4'd5;
            7'b0000010: dec_val = 4'd6;
            7'b1111000,
            7'b1011000: dec_val = 4'd7;
            7'b0000000: dec_val = 4'd8;
            7'b0010000: dec_val = 4'd9;
            7'b1111111: begin
                dec_legal = 1'b0;
                dec_blank = 1'b1;
            end
            default:    dec_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcd     <= '0;
            valid   <= '0;
            err     <= '0;
            upd     <= 1'b0;
            upd_idx <= '0;
        end else begin
            upd <= capture;
            // A coincident error capture overrides the clear for its digit.
            err <= (err_clr ? '0 : err)
                 | ((capture && !dec_legal && !dec_blank) ? sel : '0);
            if (capture) begin
                upd_idx <= idx;
                valid   <= dec_legal ? (valid | sel) : (valid & ~sel);
                for (int i = 0; i < DIGITS; i++) begin
                    if (sel[i] && dec_legal)
                        bcd[4*i +: 4] <= dec_val;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_reader.sv
// Directed bench for seg7_reader with DIGITS=4, STABLE=4.
module tb_seg7_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  seg_n = '1;
    logic [3:0]  an_n = '1;
    logic        err_clr = 1'b0;
    logic [15:0] bcd;
    logic [3:0]  valid;
    logic [3:0]  err;
    logic        upd;
    logic [2:0]  upd_idx;

    int checks = 0;
    int failures = 0;

    seg7_reader #(.DIGITS(4), .STABLE(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .seg_n   (seg_n),
        .an_n    (an_n),
        .err_clr (err_clr),
        .bcd     (bcd),
        .valid   (valid),
        .err     (err),
        .upd     (upd),
        .upd_idx (upd_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  an;
        logic [6:0]  seg;
        int          hold;
        int          n_upd;
        logic [2:0]  idx;
        logic [15:0] bcd;
        logic [3:0]  valid;
        logic [3:0]  err;
        bit          run0;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Steps n clock edges, sampling 1 time unit after each edge.
    task automatic step(input int n, output int cnt, output logic [2:0] lidx);
        cnt  = 0;
        lidx = '0;
        for (int j = 0; j < n; j++) begin
            @(posedge clk);
            #1;
            if (upd === 1'b1) begin
                cnt++;
                lidx = upd_idx;
            end
        end
    endtask

    int         cnt;
    logic [2:0] lidx;

    initial begin
        // Full scan, 6-cycle slots, digits 0..9 with both encodings of 7.
        vecs[0]  = '{4'b1110, 7'b1000000, 6, 1, 3'd0, 16'h0000, 4'b0001, 4'b0000, 1'b0};
        vecs[1]  = '{4'b1101, 7'b1111001, 6, 1, 3'd1, 16'h0010, 4'b0011, 4'b0000, 1'b0};
        vecs[2]  = '{4'b1011, 7'b0100100, 6, 1, 3'd2, 16'h0210, 4'b0111, 4'b0000, 1'b0};
        vecs[3]  = '{4'b0111, 7'b0110000, 6, 1, 3'd3, 16'h3210, 4'b1111, 4'b0000, 1'b0};
        vecs[4]  = '{4'b1110, 7'b0011001, 6, 1, 3'd0, 16'h3214, 4'b1111, 4'b0000, 1'b0};
        vecs[5]  = '{4'b1101, 7'b0010010, 6, 1, 3'd1, 16'h3254, 4'b1111, 4'b0000, 1'b0};
        vecs[6]  = '{4'b1011, 7'b0000010, 6, 1, 3'd2, 16'h3654, 4'b1111, 4'b0000, 1'b0};
        vecs[7]  = '{4'b0111, 7'b1111000, 6, 1, 3'd3, 16'h7654, 4'b1111, 4'b0000, 1'b0};
        vecs[8]  = '{4'b1110, 7'b0000000, 6, 1, 3'd0, 16'h7658, 4'b1111, 4'b0000, 1'b0};
        vecs[9]  = '{4'b1101, 7'b0010000, 6, 1, 3'd1, 16'h7698, 4'b1111, 4'b0000, 1'b0};
        vecs[10] = '{4'b1011, 7'b1011000, 6, 1, 3'd2, 16'h7798, 4'b1111, 4'b0000, 1'b0};
        // Illegal then blank on digit 0.
        vecs[11] = '{4'b1110, 7'b0001000, 8, 1, 3'd0, 16'h7798, 4'b1110, 4'b0001, 1'b0};
        vecs[12] = '{4'b1110, 7'b1111111, 8, 1, 3'd0, 16'h7798, 4'b1110, 4'b0001, 1'b0};
        // Unqualified enables with a legal segment pattern.
        vecs[13] = '{4'b1111, 7'b0110000, 10, 0, 3'd0, 16'h7798, 4'b1110, 4'b0001, 1'b1};
        vecs[14] = '{4'b0011, 7'b0110000, 10, 0, 3'd0, 16'h7798, 4'b1110, 4'b0001, 1'b1};

        #12;
        chk("reset bcd", 32'(bcd), 32'h0);
        chk("reset valid", 32'(valid), 32'h0);
        chk("reset err", 32'(err), 32'h0);
        chk("reset upd", 32'(upd), 32'h0);
        chk("reset upd_idx", 32'(upd_idx), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 15; i++) begin
            an_n  = vecs[i].an;
            seg_n = vecs[i].seg;
            step(vecs[i].hold, cnt, lidx);
            chk($sformatf("v%0d upd_count", i), 32'(cnt), 32'(vecs[i].n_upd));
            if (vecs[i].n_upd > 0)
                chk($sformatf("v%0d upd_idx", i), 32'(lidx), 32'(vecs[i].idx));
            chk($sformatf("v%0d bcd", i), 32'(bcd), 32'(vecs[i].bcd));
            chk($sformatf("v%0d valid", i), 32'(valid), 32'(vecs[i].valid));
            chk($sformatf("v%0d err", i), 32'(err), 32'(vecs[i].err));
            if (vecs[i].run0)
                chk($sformatf("v%0d run", i), 32'(dut.run), 32'h0);
        end

        // Glitch: 3 samples of "0" then "1" on digit 0; only "1" may capture.
        an_n  = 4'b1110;
        seg_n = 7'b1000000;
        step(3, cnt, lidx);
        seg_n = 7'b1111001;
        begin
            int c2;
            step(5, c2, lidx);
            chk("glitch no upd", 32'(cnt + c2), 32'h0);
        end
        chk("glitch bcd held", 32'(bcd[3:0]), 32'h8);
        step(1, cnt, lidx);
        chk("glitch upd", 32'(cnt), 32'h1);
        chk("glitch bcd new", 32'(bcd[3:0]), 32'h1);
        chk("glitch valid", 32'(valid), 32'hF);

        // Error clear, then clear coincident with a new error capture.
        err_clr = 1'b1;
        step(1, cnt, lidx);
        err_clr = 1'b0;
        chk("err_clr clears", 32'(err), 32'h0);
        seg_n = 7'b0001000;
        step(5, cnt, lidx);
        chk("coincide pre upd", 32'(cnt), 32'h0);
        err_clr = 1'b1;
        step(1, cnt, lidx);
        err_clr = 1'b0;
        chk("coincide upd", 32'(cnt), 32'h1);
        chk("coincide err", 32'(err), 32'h1);
        chk("coincide valid", 32'(valid), 32'hE);

        // Reset mid-run at run=3, then a full run is required again.
        an_n  = 4'b1101;
        seg_n = 7'b0010010;
        step(5, cnt, lidx);
        chk("midrun run", 32'(dut.run), 32'h3);
        rst = 1'b1;
        #1;
        chk("async rst bcd", 32'(bcd), 32'h0);
        chk("async rst valid", 32'(valid), 32'h0);
        chk("async rst err", 32'(err), 32'h0);
        chk("async rst upd_idx", 32'(upd_idx), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        step(5, cnt, lidx);
        chk("post rst early upd", 32'(cnt), 32'h0);
        step(1, cnt, lidx);
        chk("post rst upd", 32'(cnt), 32'h1);
        chk("post rst upd_idx", 32'(lidx), 32'h1);
        chk("post rst bcd", 32'(bcd), 32'h0050);
        chk("post rst valid", 32'(valid), 32'h2);
        step(3, cnt, lidx);
        chk("post rst no repeat", 32'(cnt), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
